// File: rtl/wb_ram_burst_if.sv
// Wishbone B3 slave bus bundle for wb_ram_burst; signal names are from the slave's viewpoint.
interface wb_ram_burst_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );
endinterface

// File: rtl/wb_ram_burst.sv
// Wishbone B3 single-port RAM slave with registered ack/err and classic, constant-address
// and incrementing (linear, wrap-4/8/16) bursts at one beat per cycle.
module wb_ram_burst #(
    parameter int unsigned DEPTH = 2048,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input logic           wb_clk_i,
    input logic           wb_rst_ni,
    wb_ram_burst_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StSingle, StBurst} state_e;

    localparam logic [2:0] CtiConst = 3'b001;
    localparam logic [2:0] CtiIncr  = 3'b010;
    localparam logic [2:0] CtiEnd   = 3'b111;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [31:0]   dat_q, dat_d;
    logic [31:0]   mem [DEPTH];

    logic          req, out_of_range, burst_cti, wr_en, rd_en;
    logic [AW-1:0] req_addr, wrap_mask, next_addr, rd_addr;
    logic [31:0]   byte_mask, rd_word;
    logic          unused_adr;

    assign req          = bus.wb_cyc_i & bus.wb_stb_i;
    assign req_addr     = bus.wb_adr_i[AW+1:2];
    assign out_of_range = |bus.wb_adr_i[31:AW+2];
    assign burst_cti    = (bus.wb_cti_i == CtiConst) | (bus.wb_cti_i == CtiIncr);
    assign unused_adr   = ^bus.wb_adr_i[1:0];
    // ack_q is only high while a beat is being terminated, so it gates the write
    assign wr_en        = ack_q & req & bus.wb_we_i;
    assign byte_mask    = {{8{bus.wb_sel_i[3]}}, {8{bus.wb_sel_i[2]}},
                           {8{bus.wb_sel_i[1]}}, {8{bus.wb_sel_i[0]}}};

    always_comb begin
        case (bus.wb_bte_i)
            2'b01:   wrap_mask = AW'(3);
            2'b10:   wrap_mask = AW'(7);
            2'b11:   wrap_mask = AW'(15);
            default: wrap_mask = '1;
        endcase
    end

    always_comb begin
        next_addr = addr_q;
        if (bus.wb_cti_i == CtiIncr) begin
            next_addr = (addr_q & ~wrap_mask) | ((addr_q + AW'(1)) & wrap_mask);
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rd_en   = 1'b0;
        rd_addr = addr_q;
        case (state_q)
            StIdle: begin
                if (req) begin
                    addr_d  = req_addr;
                    rd_addr = req_addr;
                    if (out_of_range) begin
                        state_d = StSingle;
                        err_d   = 1'b1;
                    end else begin
                        state_d = burst_cti ? StBurst : StSingle;
                        ack_d   = 1'b1;
                        rd_en   = 1'b1;
                    end
                end
            end
            StSingle: state_d = StIdle;
            StBurst: begin
                if (!req) begin
                    state_d = StIdle;
                end else begin
                    addr_d = next_addr;
                    if (bus.wb_cti_i == CtiEnd) begin
                        state_d = StIdle;
                    end else begin
                        // Prefetch the next beat so its data is ready with the following ack
                        ack_d   = 1'b1;
                        rd_en   = 1'b1;
                        rd_addr = next_addr;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rd_word = mem[rd_addr];
        // Constant-address bursts read the word being written on the same edge
        if (wr_en && (rd_addr == addr_q)) begin
            rd_word = (rd_word & ~byte_mask) | (bus.wb_dat_i & byte_mask);
        end
        dat_d = rd_en ? rd_word : dat_q;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= StIdle;
            addr_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wb_sel_i[b]) begin
                    mem[addr_q][8*b +: 8] <= bus.wb_dat_i[8*b +: 8];
                end
            end
        end
    end

    assign bus.wb_dat_o = dat_q;
    assign bus.wb_ack_o = ack_q;
    assign bus.wb_err_o = err_q;
    assign bus.wb_rty_o = 1'b0;
endmodule

// File: doc/wb_ram_burst.md
# wb_ram_burst

Wishbone B3 single-port RAM slave with registered acknowledge and classic, constant-address and incrementing-burst support, including linear and wrap-4/8/16 modes. It sits directly downstream of the memory-port arbiter and serves both the OR1200 instruction and data masters. Its bursts keep instruction-cache line refills at one beat per cycle.

## Interface
Parameters:
- DEPTH, 2048: memory size in 32-bit words; must be a power of two, minimum 16.
- AW, $clog2(DEPTH): word-address width, derived; do not override.

Ports:
- wb_clk_i  in  1  clock; all logic is on the rising edge.
- wb_rst_ni  in  1  reset; asynchronous assert, active-low.
- wb_adr_i  in  32  byte address; bits [AW+1:2] select the word.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte enables; bit n covers dat[8n+7:8n].
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_cti_i  in  3  cycle type: 000 classic, 001 constant, 010 incrementing, 111 end-of-burst.
- wb_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- wb_dat_o  out  32  read data, valid while wb_ack_o is high.
- wb_ack_o  out  1  normal termination.
- wb_err_o  out  1  error termination.
- wb_rty_o  out  1  tied to 0.

## Operation
- Reset values: wb_ack_o=0, wb_err_o=0, wb_dat_o=0, state=IDLE, burst address=0. Memory contents are not reset.
- Request: wb_cyc_i & wb_stb_i high. Out-of-range means wb_adr_i[31:2] >= DEPTH.
- State machine:
  - IDLE -> SINGLE when a request arrives with cti in {000, 111}, or with any other cti while out of range.
  - IDLE -> BURST when a request arrives with cti in {001, 010} and in range.
  - SINGLE -> IDLE after one cycle. It issues one ack (or err) pulse for exactly one cycle.
  - BURST: ack stays high on every cycle that the request stays high.
  - BURST -> IDLE when the acked beat has cti=111, or on the first cycle the request is low.
- Burst address: the internal counter is loaded with wb_adr_i[AW+1:2] on entry. It advances on every acked beat. Once the burst is in progress, wb_adr_i is ignored.
- Next address for incrementing bursts: next = (a & ~m) | ((a+1) & m). m = all ones for linear, 3 for wrap4, 7 for wrap8, 15 for wrap16.
  - Linear bursts wrap modulo DEPTH.
  - cti=001 holds the address constant.
- Reads: the RAM is read from the next-beat address so that dat_o is ready with each ack. This requires zero-bubble prefetch.
- Writes: when the beat is acked, bytes with sel=1 are written at the current beat address. Bytes with sel=0 are unchanged.
- Errors:
  - An out-of-range request gets wb_err_o instead of ack for one cycle, then returns to IDLE.
  - An errored beat never writes.
  - ack and err are never both high.
- A master stall (stb low while cyc high) in BURST returns to IDLE. The next strobe starts a new access at wb_adr_i.
- Dropping cyc at any time returns to IDLE on the next edge.
- Reset mid-burst: ack and err clear immediately, asynchronously. Any write on an unacked beat is lost.

## Timing
- Classic cycle:
  - Request seen at edge 0 -> ack high during cycle 1 -> ack low in cycle 2, regardless of stb.
  - If stb is still high at the edge that ends cycle 2, that is a new access, acked in cycle 3.
  - Throughput is 1 word per 2 cycles.
- Burst of N beats: first ack in cycle 1, then acks contiguous through cycle N, one beat per cycle. ack is low in cycle N+1.
- Read latency is 1 cycle from the request to the first data, and 0 extra cycles per subsequent burst beat.
- err has the same 1-cycle latency as ack.

## Test plan
- Classic write then read:
  - Write adr 0x10, dat 0xDEADBEEF, sel 1111 -> ack one cycle after stb, 1 cycle wide.
  - Read adr 0x10 -> dat_o = 0xDEADBEEF with ack.
- Byte lanes: preload 0x11223344, write sel=0101 with dat 0xAABBCCDD -> readback 0x11BB33DD.
- Wrap4 read burst:
  - Memory word k = k. Burst from adr 0x38 (word 14), cti 010, bte 01, 4 beats with last cti=111.
  - dat_o sequence is 14, 15, 12, 13 on 4 consecutive ack cycles, then ack low.
- Linear write burst:
  - 8 beats from word 0, data 0x100+i, stb held -> 8 contiguous acks.
  - A classic readback of word 7 returns 0x107.
- Error: read or write at adr (DEPTH*4) -> wb_err_o for one cycle, ack stays 0, no memory word changes.
- Stall and reset:
  - Deassert stb after beat 2 of a linear burst -> ack drops next cycle. A fresh stb at word 9 gets its first ack 1 cycle later.
  - Assert wb_rst_ni=0 mid-burst -> ack=0 immediately, state IDLE, earlier written words retained.
